// File: rtl/fp_minmax_prep.sv
// Operand-preparation stage for the FP min/max datapath: 2-entry skid FIFO,
// NaN / signed-zero resolution with bypass, and NV flag generation.
module fp_minmax_prep #(
   parameter int DATA_WIDTH = 64,
   parameter int EXP_WIDTH  = 11,
   parameter int MAN_WIDTH  = 52
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_valid,
   output logic                  out_ready,
   input  logic [DATA_WIDTH-1:0] in_numA,
   input  logic [DATA_WIDTH-1:0] in_numB,
   input  logic                  in_ctrl_minmax,
   output logic                  out_valid,
   input  logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_numA,
   output logic [DATA_WIDTH-1:0] out_numB,
   output logic                  out_ctrl_minmax,
   output logic                  out_bypass,
   output logic [DATA_WIDTH-1:0] out_bypass_num,
   output logic                  out_flag_nv,
   input  logic                  in_clr_flags,
   output logic                  out_nv_sticky
);

   localparam logic [DATA_WIDTH-1:0] CANON_NAN =
      {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] NEG_ZERO = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef struct packed {
      logic [DATA_WIDTH-1:0] num_a;
      logic [DATA_WIDTH-1:0] num_b;
      logic                  ctrl;
      logic                  bypass;
      logic [DATA_WIDTH-1:0] bypass_num;
      logic                  nv;
   } entry_t;

   function automatic logic is_nan(input logic [DATA_WIDTH-1:0] x);
      return (&x[DATA_WIDTH-2 -: EXP_WIDTH]) && (|x[MAN_WIDTH-1:0]);
   endfunction

   function automatic logic is_snan(input logic [DATA_WIDTH-1:0] x);
      return is_nan(x) && !x[MAN_WIDTH-1];
   endfunction

   function automatic logic is_zero(input logic [DATA_WIDTH-1:0] x);
      return ~|x[DATA_WIDTH-2:0];
   endfunction

   entry_t     head_q, tail_q, new_entry;
   logic [1:0] count_q;
   logic       push, pop;
   logic       nan_a, nan_b, zero_a, zero_b;

   assign out_ready = (count_q < 2'd2) && !in_rst;
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && out_ready;
   assign pop       = out_valid && in_ready;

   // NOTE: every field gets a default before the case logic so no latch is inferred.
   always_comb begin
      nan_a                = is_nan(in_numA);
      nan_b                = is_nan(in_numB);
      zero_a               = is_zero(in_numA);
      zero_b               = is_zero(in_numB);
      new_entry            = '0;
      new_entry.num_a      = in_numA;
      new_entry.num_b      = in_numB;
      new_entry.ctrl       = in_ctrl_minmax;
      new_entry.nv         = is_snan(in_numA) || is_snan(in_numB);
      if (nan_a && nan_b) begin
         new_entry.bypass     = 1'b1;
         new_entry.bypass_num = CANON_NAN;
      end else if (nan_a || nan_b) begin
         new_entry.bypass     = 1'b1;
         new_entry.bypass_num = nan_a ? in_numB : in_numA;
      end else if (zero_a && zero_b) begin
         new_entry.bypass = 1'b1;
         // Mixed-sign zeros: min prefers -0, max prefers +0.
         if (in_numA[DATA_WIDTH-1] != in_numB[DATA_WIDTH-1])
            new_entry.bypass_num = in_ctrl_minmax ? '0 : NEG_ZERO;
         else
            new_entry.bypass_num = in_numA;
      end
   end

   // NOTE: both slots are reset because the data outputs must read 0 after reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         count_q       <= 2'd0;
         head_q        <= '0;
         tail_q        <= '0;
         out_nv_sticky <= 1'b0;
      end else begin
         if (push && pop) begin
            head_q <= new_entry;
         end else if (push) begin
            if (count_q == 2'd0) head_q <= new_entry;
            else                 tail_q <= new_entry;
            count_q <= count_q + 2'd1;
         end else if (pop) begin
            head_q  <= tail_q;
            count_q <= count_q - 2'd1;
         end
         if (pop && head_q.nv)  out_nv_sticky <= 1'b1;
         else if (in_clr_flags) out_nv_sticky <= 1'b0;
      end
   end

   assign out_numA        = head_q.num_a;
   assign out_numB        = head_q.num_b;
   assign out_ctrl_minmax = head_q.ctrl;
   assign out_bypass      = head_q.bypass;
   assign out_bypass_num  = head_q.bypass_num;
   assign out_flag_nv     = head_q.nv;

endmodule

// File: tb/tb_fp_minmax_prep.sv
// Directed bench for fp_minmax_prep: table-driven classification vectors
// streamed back-to-back, plus backpressure, sticky-flag and reset sequences.
module tb_fp_minmax_prep;

   localparam logic [63:0] ONE   = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] TWO   = 64'h4000_0000_0000_0000;
   localparam logic [63:0] PZERO = 64'h0000_0000_0000_0000;
   localparam logic [63:0] NZERO = 64'h8000_0000_0000_0000;
   localparam logic [63:0] CNAN  = 64'h7FF8_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, in_ctrl_minmax, out_valid, in_ready;
   logic [63:0] in_numA, in_numB, out_numA, out_numB, out_bypass_num;
   logic        out_ctrl_minmax, out_bypass, out_flag_nv, in_clr_flags, out_nv_sticky;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fp_minmax_prep dut (
      .in_clk(clk), .in_rst(rst), .in_valid(in_valid), .out_ready(out_ready),
      .in_numA(in_numA), .in_numB(in_numB), .in_ctrl_minmax(in_ctrl_minmax),
      .out_valid(out_valid), .in_ready(in_ready), .out_numA(out_numA),
      .out_numB(out_numB), .out_ctrl_minmax(out_ctrl_minmax), .out_bypass(out_bypass),
      .out_bypass_num(out_bypass_num), .out_flag_nv(out_flag_nv),
      .in_clr_flags(in_clr_flags), .out_nv_sticky(out_nv_sticky)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        mx;
      logic        byp;
      logic [63:0] res;
      logic        nv;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic mx);
      in_valid       = v;
      in_numA        = a;
      in_numB        = b;
      in_ctrl_minmax = mx;
   endtask

   initial begin
      vecs[0]  = '{ONE, TWO, 1'b1, 1'b0, 64'h0, 1'b0};
      vecs[1]  = '{64'h7FF0_0000_0000_0001, ONE, 1'b0, 1'b1, ONE, 1'b1};
      vecs[2]  = '{CNAN, 64'hFFF8_0000_0000_0001, 1'b1, 1'b1, CNAN, 1'b0};
      vecs[3]  = '{PZERO, NZERO, 1'b0, 1'b1, NZERO, 1'b0};
      vecs[4]  = '{PZERO, NZERO, 1'b1, 1'b1, PZERO, 1'b0};
      vecs[5]  = '{NZERO, NZERO, 1'b1, 1'b1, NZERO, 1'b0};
      vecs[6]  = '{ONE, 64'hFFF8_0000_0000_0001, 1'b1, 1'b1, ONE, 1'b0};
      vecs[7]  = '{64'h7FF4_0000_0000_0000, 64'hFFF0_0000_0000_0001, 1'b0, 1'b1, CNAN, 1'b1};
      vecs[8]  = '{64'h7FF0_0000_0000_0000, ONE, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[9]  = '{PZERO, ONE, 1'b0, 1'b0, 64'h0, 1'b0};
      vecs[10] = '{64'hC000_0000_0000_0000, 64'hFFF0_0000_0000_0002, 1'b1, 1'b1, 64'hC000_0000_0000_0000, 1'b1};

      rst = 1'b1; in_ready = 1'b0; in_clr_flags = 1'b0;
      drive(1'b0, 64'h0, 64'h0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {63'h0, out_ready}, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", {63'h0, out_valid}, 64'h0);
      check("rst_ready_after", {63'h0, out_ready}, 64'h1);
      check("rst_sticky", {63'h0, out_nv_sticky}, 64'h0);
      check("rst_numA", out_numA, 64'h0);

      // Back-to-back stream, one pair per cycle, checked the cycle after push.
      in_ready = 1'b1;
      for (int i = 0; i <= 11; i++) begin
         if (i > 0) begin
            check($sformatf("v%0d_valid", i-1), {63'h0, out_valid}, 64'h1);
            check($sformatf("v%0d_ready", i-1), {63'h0, out_ready}, 64'h1);
            check($sformatf("v%0d_numA", i-1), out_numA, vecs[i-1].a);
            check($sformatf("v%0d_numB", i-1), out_numB, vecs[i-1].b);
            check($sformatf("v%0d_ctrl", i-1), {63'h0, out_ctrl_minmax}, {63'h0, vecs[i-1].mx});
            check($sformatf("v%0d_byp", i-1), {63'h0, out_bypass}, {63'h0, vecs[i-1].byp});
            check($sformatf("v%0d_res", i-1), out_bypass_num, vecs[i-1].res);
            check($sformatf("v%0d_nv", i-1), {63'h0, out_flag_nv}, {63'h0, vecs[i-1].nv});
         end
         if (i < 11) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].mx);
         else        drive(1'b0, 64'h0, 64'h0, 1'b0);
         @(negedge clk);
      end
      check("stream_empty", {63'h0, out_valid}, 64'h0);
      check("stream_sticky", {63'h0, out_nv_sticky}, 64'h1);
      in_clr_flags = 1'b1;
      @(negedge clk);
      in_clr_flags = 1'b0;
      check("clr_sticky", {63'h0, out_nv_sticky}, 64'h0);

      // Backpressure: three pairs offered with in_ready low.
      in_ready = 1'b0;
      drive(1'b1, 64'h1, 64'h11, 1'b0);
      @(negedge clk);
      check("bp_head0", out_numA, 64'h1);
      check("bp_ready1", {63'h0, out_ready}, 64'h1);
      drive(1'b1, 64'h2, 64'h22, 1'b1);
      @(negedge clk);
      check("bp_ready_full", {63'h0, out_ready}, 64'h0);
      drive(1'b1, 64'h3, 64'h33, 1'b0);
      @(negedge clk);
      check("bp_hold_ready", {63'h0, out_ready}, 64'h0);
      check("bp_hold_numA", out_numA, 64'h1);
      check("bp_hold_numB", out_numB, 64'h11);
      in_ready = 1'b1;
      @(negedge clk);
      check("bp_pop1_numA", out_numA, 64'h2);
      check("bp_pop1_ctrl", {63'h0, out_ctrl_minmax}, 64'h1);
      check("bp_pop1_ready", {63'h0, out_ready}, 64'h1);
      @(negedge clk);
      check("bp_pop2_numA", out_numA, 64'h3);
      check("bp_pop2_valid", {63'h0, out_valid}, 64'h1);
      drive(1'b0, 64'h0, 64'h0, 1'b0);
      @(negedge clk);
      check("bp_drained", {63'h0, out_valid}, 64'h0);

      // NV pop and clear at the same edge: set wins.
      in_ready = 1'b0;
      drive(1'b1, 64'h7FF0_0000_0000_0001, ONE, 1'b0);
      @(negedge clk);
      drive(1'b0, 64'h0, 64'h0, 1'b0);
      check("nv_head", {63'h0, out_flag_nv}, 64'h1);
      check("nv_unpopped", {63'h0, out_nv_sticky}, 64'h0);
      in_ready = 1'b1; in_clr_flags = 1'b1;
      @(negedge clk);
      check("nv_set_wins", {63'h0, out_nv_sticky}, 64'h1);
      in_ready = 1'b0;

      // Reset with the FIFO full and sticky set.
      drive(1'b1, 64'h5, 64'h55, 1'b1);
      in_clr_flags = 1'b0;
      @(negedge clk);
      drive(1'b1, 64'h6, 64'h66, 1'b1);
      @(negedge clk);
      check("full_before_rst", {63'h0, out_ready}, 64'h0);
      drive(1'b0, 64'h0, 64'h0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", {63'h0, out_valid}, 64'h0);
      check("mid_rst_ready", {63'h0, out_ready}, 64'h0);
      check("mid_rst_sticky", {63'h0, out_nv_sticky}, 64'h0);
      check("mid_rst_numA", out_numA, 64'h0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_ready", {63'h0, out_ready}, 64'h1);
      check("post_rst_valid", {63'h0, out_valid}, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
